// File: rtl/he_ctrl_pkg.sv
// Shared types and defaults for the HE job sequencers.
// BIT_WIDTH_DEF is the default coefficient width; instances override it by parameter.
package he_ctrl_pkg;
  localparam int BIT_WIDTH_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int WDOG_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE, RD, RWAIT, ISSUE, PWAIT, WR, FIN, ERR
  } seq_state_e;
endpackage

// File: rtl/he_wdog.sv
// Saturating watchdog counter. The limit is 2**WDOG_W-1 counted cycles, and
// expired flags the cycle in which the last allowed cycle is being counted.
module he_wdog #(
  parameter int WDOG_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [WDOG_W-1:0] LIMIT = '1;

  logic [WDOG_W-1:0] cnt;

  // NOTE: state registers take non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt >= LIMIT - 1'b1);
endmodule

// File: rtl/he_scale_seq.sv
// Job sequencer: streams LEN coefficients from RAM through one scale-and-round
// processor and writes the results back, one coefficient in flight at a time.
module he_scale_seq
  import he_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WDOG_W    = WDOG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    len_i,
  input  logic [ADDR_W-1:0]    src_i,
  input  logic [ADDR_W-1:0]    dst_i,
  input  logic [BIT_WIDTH-1:0] t_i,
  input  logic [BIT_WIDTH-1:0] q_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 rd_en_o,
  output logic [ADDR_W-1:0]    rd_addr_o,
  input  logic [BIT_WIDTH-1:0] rd_data_i,
  output logic                 wr_en_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [BIT_WIDTH-1:0] wr_data_o,
  output logic [BIT_WIDTH-1:0] p_t_o,
  output logic [BIT_WIDTH-1:0] p_q_o,
  output logic [BIT_WIDTH-1:0] p_data_o,
  output logic                 p_valid_o,
  input  logic                 p_ready_i,
  input  logic [BIT_WIDTH-1:0] p_data_i,
  input  logic                 p_done_i
);
  seq_state_e state, state_nxt;

  logic [ADDR_W-1:0]    idx, len_q, src_q, dst_q;
  logic [BIT_WIDTH-1:0] t_q, q_q, opnd_q, res_q;
  logic                 wd_clear, wd_enable, wd_expired;

  he_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // NOTE: the data registers are reset too, so every output reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= '0;
      len_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      t_q    <= '0;
      q_q    <= '0;
      opnd_q <= '0;
      res_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start_i) begin
          len_q <= len_i;
          src_q <= src_i;
          dst_q <= dst_i;
          t_q   <= t_i;
          q_q   <= q_i;
          idx   <= '0;
        end
        RWAIT:   opnd_q <= rd_data_i;
        PWAIT:   if (p_done_i) res_q <= p_data_i;
        WR:      idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    busy_o    = (state != IDLE);
    done_o    = 1'b0;
    err_o     = 1'b0;
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    p_data_o  = '0;
    p_valid_o = 1'b0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = (len_i == '0) ? FIN : RD;
      RD: begin
        rd_en_o   = 1'b1;
        rd_addr_o = src_q + idx;
        state_nxt = RWAIT;
      end
      RWAIT: state_nxt = ISSUE;
      ISSUE: begin
        wd_enable = 1'b1;
        if (p_ready_i) begin
          p_valid_o = 1'b1;
          p_data_o  = opnd_q;
          wd_clear  = 1'b1;
          state_nxt = PWAIT;
        end
      end
      PWAIT: begin
        wd_enable = 1'b1;
        if (p_done_i)        state_nxt = WR;
        else if (wd_expired) state_nxt = ERR;
      end
      WR: begin
        wr_en_o   = 1'b1;
        wr_addr_o = dst_q + idx;
        wr_data_o = res_q;
        state_nxt = ((idx + 1'b1) == len_q) ? FIN : RD;
      end
      FIN: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err_o     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The state register still holds the old job during the reset cycle; keep its strobes quiet.
    if (!rst) begin
      busy_o    = 1'b0;
      done_o    = 1'b0;
      err_o     = 1'b0;
      rd_en_o   = 1'b0;
      wr_en_o   = 1'b0;
      p_valid_o = 1'b0;
    end
  end

  assign p_t_o = t_q;
  assign p_q_o = q_q;
endmodule

// File: tb/tb_he_scale_seq.sv
// Directed bench for he_scale_seq with a RAM model and a stallable
// processor model computing floor(x*t/q) mod q after a short latency.
module tb_he_scale_seq;
  localparam int BW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0, src = '0, dst = '0;
  logic [BW-1:0] t = '0, q = '0;
  logic          busy_o, done_o, err_o, rd_en_o, wr_en_o, p_valid_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [BW-1:0] wr_data_o, p_t_o, p_q_o, p_data_o;
  logic [BW-1:0] rd_data = '0;
  logic [BW-1:0] p_dout = '0;
  logic          p_done = 1'b0;
  logic          p_ready;

  logic [BW-1:0] mem [0:1023];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [BW-1:0] pl_data = '0;

  logic          stall = 1'b0;
  logic          pbusy = 1'b0;
  int            cd = 0;
  logic [BW-1:0] acc = '0;

  int rd_cnt = 0, wr_cnt = 0, pv_cnt = 0, done_cnt = 0, err_cnt = 0;
  int cyc = 0, pv_cyc = 0, err_cyc = 0;
  int rd_log[$];
  int wr_log[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  he_scale_seq #(.BIT_WIDTH(BW), .ADDR_W(AW), .WDOG_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .len_i(len), .src_i(src), .dst_i(dst),
    .t_i(t), .q_i(q), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .p_t_o(p_t_o), .p_q_o(p_q_o), .p_data_o(p_data_o), .p_valid_o(p_valid_o),
    .p_ready_i(p_ready), .p_data_i(p_dout), .p_done_i(p_done)
  );

  assign p_ready = !pbusy;

  // RAM, processor model and event bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_o) begin
      rd_data <= mem[rd_addr_o];
      rd_cnt  <= rd_cnt + 1;
      rd_log.push_back(int'(rd_addr_o));
    end
    if (wr_en_o) begin
      mem[wr_addr_o] <= wr_data_o;
      wr_cnt <= wr_cnt + 1;
      wr_log.push_back(int'(wr_addr_o));
    end
    if (pl_en) mem[pl_addr] <= pl_data;
    if (done_o) done_cnt <= done_cnt + 1;
    if (err_o) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    p_done <= 1'b0;
    if (p_valid_o) begin
      pv_cnt <= pv_cnt + 1;
      pv_cyc <= cyc;
      pbusy  <= 1'b1;
      cd     <= 2;
      acc    <= BW'((32'(p_data_o) * 32'(p_t_o) / 32'(p_q_o)) % 32'(p_q_o));
    end else if (pbusy && !stall) begin
      if (cd == 0) begin
        p_done <= 1'b1;
        p_dout <= acc;
        pbusy  <= 1'b0;
      end else begin
        cd <= cd - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input int d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = AW'(a); pl_data = BW'(d);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic launch(input int l, input int s, input int d, input int tt, input int qq);
    @(negedge clk);
    start = 1'b1; len = AW'(l); src = AW'(s); dst = AW'(d); t = BW'(tt); q = BW'(qq);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output logic d, output logic e, output int lat);
    lat = 1;
    while (!done_o && !err_o && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    d = done_o;
    e = err_o;
    if (!d && !e) check("job_timeout", 0, 1);
  endtask

  initial begin
    logic d, e;
    int   lat, r0, w0, p0, d0, n, b;
    int   exp_addr[4];

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(|{busy_o, done_o, err_o, rd_en_o, wr_en_o, p_valid_o,
                                 rd_addr_o, wr_addr_o, wr_data_o, p_t_o, p_q_o, p_data_o}), 0);
    rst = 1'b1;

    // 1: basic job, t=16 q=97
    poke(0, 50); poke(1, 96); poke(2, 0); poke(3, 1);
    d0 = done_cnt;
    launch(4, 0, 8, 16, 97);
    wait_end(200, d, e, lat);
    check("t1_done", 32'(d), 1);
    check("t1_busy_at_done", 32'(busy_o), 1);
    @(negedge clk);
    check("t1_busy_after", 32'(busy_o), 0);
    check("t1_done_pulses", 32'(done_cnt - d0), 1);
    check("t1_ram8", 32'(mem[8]), 8);
    check("t1_ram9", 32'(mem[9]), 15);
    check("t1_ram10", 32'(mem[10]), 0);
    check("t1_ram11", 32'(mem[11]), 0);

    // 2: zero-length job
    r0 = rd_cnt; w0 = wr_cnt; p0 = pv_cnt;
    launch(0, 5, 6, 16, 97);
    wait_end(20, d, e, lat);
    check("t2_done", 32'(d), 1);
    check("t2_latency", 32'(lat), 1);
    @(negedge clk);
    check("t2_reads", 32'(rd_cnt - r0), 0);
    check("t2_writes", 32'(wr_cnt - w0), 0);
    check("t2_issues", 32'(pv_cnt - p0), 0);

    // 3: in-place job across the address wrap
    poke(1022, 10); poke(1023, 20); poke(0, 30); poke(1, 40);
    r0 = rd_log.size(); w0 = wr_log.size();
    launch(4, 1022, 1022, 16, 97);
    wait_end(200, d, e, lat);
    check("t3_done", 32'(d), 1);
    exp_addr = '{1022, 1023, 0, 1};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_rd_addr%0d", i), 32'(rd_log[r0 + i]), 32'(exp_addr[i]));
      check($sformatf("t3_wr_addr%0d", i), 32'(wr_log[w0 + i]), 32'(exp_addr[i]));
    end
    check("t3_ram1023", 32'(mem[1023]), 3);

    // 4: stalled processor trips the watchdog, then a normal job
    poke(40, 50); poke(42, 60);
    stall = 1'b1;
    w0 = wr_cnt;
    launch(1, 40, 41, 16, 97);
    wait_end(400, d, e, lat);
    check("t4_err", 32'(e), 1);
    @(negedge clk);
    check("t4_err_delay", 32'(err_cyc - pv_cyc), 256);
    check("t4_no_write", 32'(wr_cnt - w0), 0);
    stall = 1'b0;
    launch(1, 42, 43, 16, 97);
    wait_end(100, d, e, lat);
    check("t4_next_done", 32'(d), 1);
    @(negedge clk);
    check("t4_next_ram43", 32'(mem[43]), 9);

    // 5: start pulsed mid-job with other settings is ignored
    poke(20, 50); poke(21, 96);
    w0 = wr_cnt; d0 = done_cnt;
    launch(2, 20, 30, 16, 97);
    repeat (3) @(negedge clk);
    start = 1'b1; len = AW'(5); t = BW'(3); q = BW'(7);
    @(negedge clk);
    start = 1'b0;
    wait_end(200, d, e, lat);
    @(negedge clk);
    check("t5_ram30", 32'(mem[30]), 8);
    check("t5_ram31", 32'(mem[31]), 15);
    check("t5_writes", 32'(wr_cnt - w0), 2);
    check("t5_done_pulses", 32'(done_cnt - d0), 1);
    check("t5_p_t", 32'(p_t_o), 16);
    check("t5_p_q", 32'(p_q_o), 97);

    // 6: reset while waiting on the processor
    poke(44, 50);
    stall = 1'b1;
    w0 = wr_cnt; d0 = done_cnt; p0 = pv_cnt;
    launch(1, 44, 45, 16, 97);
    n = 0;
    while (pv_cnt == p0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_issued", 32'(pv_cnt - p0), 1);
    repeat (3) @(negedge clk);
    b = int'(busy_o);
    check("t6_busy_in_pwait", 32'(b), 1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_reset_outputs", 32'(|{busy_o, done_o, err_o, rd_en_o, wr_en_o, p_valid_o,
                                    rd_addr_o, wr_addr_o, wr_data_o, p_t_o, p_q_o, p_data_o}), 0);
    rst = 1'b1;
    stall = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_write", 32'(wr_cnt - w0), 0);
    check("t6_no_done", 32'(done_cnt - d0), 0);
    check("t6_idle", 32'(busy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
